// File: rtl/load_store_unit.sv
// Initiator side of the byte-lane data memory port: sequences one load or store
// at a time against a memory with a one-cycle synchronous read.
module load_store_unit #(
    parameter bit ALLOW_MISALIGNED = 1'b1,
    localparam int unsigned ADDR_W = 32,
    localparam int unsigned DATA_W = 32,
    localparam int unsigned SIZE_W = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [SIZE_W-1:0] req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_address,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_data,
    output logic              resp_error,
    output logic [ADDR_W-1:0] memory_address,
    output logic [DATA_W-1:0] memory_in,
    output logic [SIZE_W-1:0] memory_size,
    output logic              memory_write_enable,
    input  logic [DATA_W-1:0] memory_out
);

    localparam logic [SIZE_W-1:0] SIZE_BYTE = 2'b00;
    localparam logic [SIZE_W-1:0] SIZE_HALF = 2'b01;
    localparam logic [SIZE_W-1:0] SIZE_WORD = 2'b10;
    localparam logic [SIZE_W-1:0] SIZE_WIDE = 2'b11;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        ACCESS  = 2'b01,
        CAPTURE = 2'b10,
        RESP    = 2'b11
    } state_t;

    state_t state;
    state_t state_next;

    logic              write_q;
    logic              signed_q;
    logic              write_next;
    logic              signed_next;
    logic              req_ready_next;
    logic              resp_valid_next;
    logic              resp_error_next;
    logic              write_enable_next;
    logic [DATA_W-1:0] resp_data_next;
    logic [ADDR_W-1:0] address_next;
    logic [DATA_W-1:0] wdata_next;
    logic [SIZE_W-1:0] size_next;

    logic [SIZE_W-1:0] size_norm;
    logic              misaligned;
    logic              reject;
    logic              accept;
    logic [DATA_W-1:0] load_value;

    // Request decode: size 11 is folded onto word before any alignment check
    always_comb begin
        size_norm  = (req_size == SIZE_WIDE) ? SIZE_WORD : req_size;
        misaligned = ((size_norm == SIZE_HALF) && req_address[0])
                   || ((size_norm == SIZE_WORD) && (req_address[1:0] != 2'b00));
        reject     = !ALLOW_MISALIGNED && misaligned;
        accept     = req_valid && req_ready;
    end

    // Only the lanes covered by the access size reach the extended result
    always_comb begin
        load_value = memory_out;
        case (memory_size)
            SIZE_BYTE: load_value = {{(DATA_W-8){signed_q & memory_out[7]}}, memory_out[7:0]};
            SIZE_HALF: load_value = {{(DATA_W-16){signed_q & memory_out[15]}}, memory_out[15:0]};
            default:   load_value = memory_out;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and next-output logic; every output is registered from these
    always_comb begin
        state_next        = state;
        write_next        = write_q;
        signed_next       = signed_q;
        resp_data_next    = resp_data;
        resp_error_next   = resp_error;
        address_next      = memory_address;
        wdata_next        = memory_in;
        size_next         = memory_size;

        case (state)
            IDLE: begin
                if (accept) begin
                    write_next  = req_write;
                    signed_next = req_signed;
                    if (reject) begin
                        state_next      = RESP;
                        resp_data_next  = '0;
                        resp_error_next = 1'b1;
                    end else begin
                        state_next   = ACCESS;
                        address_next = req_address;
                        wdata_next   = req_wdata;
                        size_next    = size_norm;
                    end
                end
            end
            ACCESS: begin
                if (write_q) begin
                    state_next      = RESP;
                    resp_data_next  = '0;
                    resp_error_next = 1'b0;
                end else begin
                    state_next = CAPTURE;
                end
            end
            CAPTURE: begin
                state_next      = RESP;
                resp_data_next  = load_value;
                resp_error_next = 1'b0;
            end
            RESP: begin
                if (resp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase

        req_ready_next    = (state_next == IDLE);
        resp_valid_next   = (state_next == RESP);
        write_enable_next = (state_next == ACCESS) && write_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            write_q             <= 1'b0;
            signed_q            <= 1'b0;
            req_ready           <= 1'b1;
            resp_valid          <= 1'b0;
            resp_data           <= '0;
            resp_error          <= 1'b0;
            memory_address      <= '0;
            memory_in           <= '0;
            memory_size         <= SIZE_BYTE;
            memory_write_enable <= 1'b0;
        end else begin
            write_q             <= write_next;
            signed_q            <= signed_next;
            req_ready           <= req_ready_next;
            resp_valid          <= resp_valid_next;
            resp_data           <= resp_data_next;
            resp_error          <= resp_error_next;
            memory_address      <= address_next;
            memory_in           <= wdata_next;
            memory_size         <= size_next;
            memory_write_enable <= write_enable_next;
        end
    end

endmodule
